fifo_bank: RTL



---
 rtl/fifo_bank.sv | 111 +++++++++++
 1 files changed

// File: rtl/fifo_bank.sv
// Single-clock bank of NCH independent FIFOs with occupancy, almost-full and
// sticky overflow/underflow reporting; read port is registered or first-word-fall-through.
module fifo_bank #(
  parameter int NCH   = 4,
  parameter int DW    = 32,
  parameter int AW    = 2,
  parameter int FWFT  = 0,
  parameter int AF_TH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        push,
  input  logic [NCH-1:0]        pop,
  input  logic [NCH*DW-1:0]     wdata,
  output logic [NCH*DW-1:0]     rdata,
  output logic [NCH-1:0]        empty,
  output logic [NCH-1:0]        full,
  output logic [NCH-1:0]        afull,
  output logic [NCH*(AW+1)-1:0] level,
  output logic [NCH-1:0]        ovf,
  output logic [NCH-1:0]        udf,
  input  logic [NCH-1:0]        err_clr
);

  localparam int DEPTH = 2**AW;
  localparam int LW    = AW + 1;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DW-1:0] mem [DEPTH];
    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic [LW-1:0] lvl;
    logic [LW-1:0] wr_nxt;
    logic [LW-1:0] rd_nxt;
    logic [LW-1:0] lvl_nxt;
    logic          empty_q;
    logic          full_q;
    logic          afull_q;
    logic          ovf_q;
    logic          udf_q;
    logic          push_ok;
    logic          pop_ok;
    logic [DW-1:0] wdat;
    logic [DW-1:0] head;

    assign wdat    = wdata[i*DW +: DW];
    assign head    = mem[rd_ptr[AW-1:0]];

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
    assign pop_ok  = pop[i] & ~empty_q;
    assign push_ok = push[i] & (~full_q | pop_ok);

    assign wr_nxt  = wr_ptr + LW'(push_ok);
    assign rd_nxt  = rd_ptr + LW'(pop_ok);
    assign lvl_nxt = wr_nxt - rd_nxt;

    // Pointer / flag stage: flags come from the next-state level so they line up with level.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        lvl     <= '0;
        empty_q <= 1'b1;
        full_q  <= 1'b0;
        afull_q <= 1'b0;
        ovf_q   <= 1'b0;
        udf_q   <= 1'b0;
      end else begin
        wr_ptr  <= wr_nxt;
        rd_ptr  <= rd_nxt;
        lvl     <= lvl_nxt;
        empty_q <= (lvl_nxt == '0);
        full_q  <= (lvl_nxt == LW'(DEPTH));
        afull_q <= (lvl_nxt >= LW'(AF_TH));
        ovf_q   <= (ovf_q & ~err_clr[i]) | (push[i] & ~push_ok);
        udf_q   <= (udf_q & ~err_clr[i]) | (pop[i] & ~pop_ok);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst && push_ok) begin
        mem[wr_ptr[AW-1:0]] <= wdat;
      end
    end

    if (FWFT != 0) begin : g_fwft
      assign rdata[i*DW +: DW] = empty_q ? '0 : head;
    end else begin : g_reg
      logic [DW-1:0] rdata_p1;

      // Registered read stage: the popped word appears one cycle after the pop.
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_p1 <= '0;
        end else if (pop_ok) begin
          rdata_p1 <= head;
        end
      end

      assign rdata[i*DW +: DW] = rdata_p1;
    end

    assign empty[i]             = empty_q;
    assign full[i]              = full_q;
    assign afull[i]             = afull_q;
    assign ovf[i]               = ovf_q;
    assign udf[i]               = udf_q;
    assign level[i*LW +: LW]    = lvl;
  end

endmodule
